// File: rtl/apb_pkg.sv
// Shared types and constants for the APB slave controller and its address decoder.
package apb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  // Write registers start at address 0. Read registers start at REGR_ADDR_OFFSET.
  localparam int WR_BASE          = 0;
  localparam int REGR_ADDR_OFFSET = 5;

  // Wait counter width. It is kept at 1 bit or more so that WAIT_CYCLES=0 still builds.
  function automatic int cnt_width(input int wait_cycles);
    return (wait_cycles < 1) ? 1 : $clog2(wait_cycles + 1);
  endfunction

endpackage

// File: rtl/apb_addr_dec.sv
// Combinational APB address decode: write/read window checks, one-hot write
// strobe vector and binary read-register index.
module apb_addr_dec
  import apb_pkg::*;
#(
  parameter int AWIDTH           = 4,
  parameter int REGWN            = 5,
  parameter int REGRN            = 3,
  parameter int REGR_ADDR_OFFSET = apb_pkg::REGR_ADDR_OFFSET
) (
  input  logic [AWIDTH-1:0] addr,
  input  logic              write,
  output logic              wr_valid,
  output logic              rd_valid,
  output logic [REGWN-1:0]  wr_onehot,
  output logic [REGRN-1:0]  rd_idx
);

  logic [31:0] a32;

  always_comb begin
    a32       = 32'(addr);
    wr_valid  = write && (a32 < 32'(WR_BASE + REGWN));
    rd_valid  = !write && (a32 >= 32'(REGR_ADDR_OFFSET)) &&
                (a32 < 32'(REGR_ADDR_OFFSET + REGRN));
    wr_onehot = '0;
    for (int i = 0; i < REGWN; i++) begin
      wr_onehot[i] = wr_valid && (a32 == 32'(WR_BASE + i));
    end
    rd_idx = REGRN'(a32 - 32'(REGR_ADDR_OFFSET));
  end

endmodule

// File: rtl/apb_slave_ctrl.sv
// APB slave sequencer: setup/access tracking, programmable wait states, write
// strobe and read select generation. Define APB_SLVERR_EN to report PSLVERR.
module apb_slave_ctrl
  import apb_pkg::*;
#(
  parameter int AWIDTH           = 4,
  parameter int DWIDTH           = 8,
  parameter int REGWN            = 5,
  parameter int REGRN            = 3,
  parameter int REGR_ADDR_OFFSET = apb_pkg::REGR_ADDR_OFFSET,
  parameter int WAIT_CYCLES      = 1
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [AWIDTH-1:0] PADDR,
  input  logic [DWIDTH-1:0] PWDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [REGWN-1:0]  pselw,
  output logic [DWIDTH-1:0] wr_data,
  output logic [REGRN-1:0]  rd_sel,
  output logic              rd_en
);

  localparam int               CNT_W   = cnt_width(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_CYCLES);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [REGWN-1:0]   wr_hot_q;
  logic               rd_ok_q;
  logic               setup, done;

  logic               dec_wr_valid, dec_rd_valid;
  logic [REGWN-1:0]   dec_wr_hot;
  logic [REGRN-1:0]   dec_rd_idx;

  apb_addr_dec #(
    .AWIDTH          (AWIDTH),
    .REGWN           (REGWN),
    .REGRN           (REGRN),
    .REGR_ADDR_OFFSET(REGR_ADDR_OFFSET)
  ) u_dec (
    .addr     (PADDR),
    .write    (PWRITE),
    .wr_valid (dec_wr_valid),
    .rd_valid (dec_rd_valid),
    .wr_onehot(dec_wr_hot),
    .rd_idx   (dec_rd_idx)
  );

  assign setup = (state == IDLE) && PSEL && !PENABLE;
  assign done  = (state == ACCESS) && (cnt == CNT_MAX);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (setup) begin
          state_nxt = ACCESS;
          cnt_nxt   = '0;
        end
      end
      ACCESS: begin
        if (done || !PSEL) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Setup edge: capture the decoded transfer. Later bus activity cannot change it.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state    <= IDLE;
      cnt      <= '0;
      wr_hot_q <= '0;
      rd_ok_q  <= 1'b0;
      wr_data  <= '0;
      rd_sel   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (setup) begin
        wr_data  <= PWDATA;
        wr_hot_q <= dec_wr_hot;
        rd_ok_q  <= dec_rd_valid;
        if (dec_rd_valid) begin
          rd_sel <= dec_rd_idx;
        end
      end
    end
  end

  assign PREADY = done;
  assign pselw  = done ? wr_hot_q : '0;
  assign rd_en  = (state == ACCESS) && rd_ok_q && PSEL;

`ifdef APB_SLVERR_EN
  // An access that is neither a valid write nor a valid read is reported as an error.
  assign PSLVERR = done && !(|wr_hot_q) && !rd_ok_q;
`else
  assign PSLVERR = 1'b0;
`endif

endmodule

// File: tb/tb_apb_slave_ctrl.sv
// Directed bench for apb_slave_ctrl. It drives three instances (WAIT_CYCLES 1, 0 and 3)
// that share the bus inputs and each have their own PSEL.
module tb_apb_slave_ctrl;

`ifdef APB_SLVERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic       clk;
  logic       preset;
  logic [2:0] psel;
  logic       penable, pwrite;
  logic [3:0] paddr;
  logic [7:0] pwdata;

  logic [2:0] pready, pslverr, rd_en;
  logic [4:0] pselw  [3];
  logic [7:0] wr_data[3];
  logic [2:0] rd_sel [3];

  int n_vec = 0;
  int n_err = 0;

  apb_slave_ctrl #(.WAIT_CYCLES(1)) u_w1 (
    .PCLK(clk), .PRESET(preset), .PSEL(psel[0]), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
    .PREADY(pready[0]), .PSLVERR(pslverr[0]), .pselw(pselw[0]),
    .wr_data(wr_data[0]), .rd_sel(rd_sel[0]), .rd_en(rd_en[0])
  );

  apb_slave_ctrl #(.WAIT_CYCLES(0)) u_w0 (
    .PCLK(clk), .PRESET(preset), .PSEL(psel[1]), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
    .PREADY(pready[1]), .PSLVERR(pslverr[1]), .pselw(pselw[1]),
    .wr_data(wr_data[1]), .rd_sel(rd_sel[1]), .rd_en(rd_en[1])
  );

  apb_slave_ctrl #(.WAIT_CYCLES(3)) u_w3 (
    .PCLK(clk), .PRESET(preset), .PSEL(psel[2]), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
    .PREADY(pready[2]), .PSLVERR(pslverr[2]), .pselw(pselw[2]),
    .wr_data(wr_data[2]), .rd_sel(rd_sel[2]), .rd_en(rd_en[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives the bus and lets the combinational outputs settle before checking.
  task automatic drv(input logic [2:0] sel, input logic en, input logic wr,
                     input logic [3:0] addr, input logic [7:0] data);
    psel    = sel;
    penable = en;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = data;
    #1;
  endtask

  initial begin
    preset = 1'b1;
    drv(3'b000, 1'b0, 1'b0, 4'd0, 8'h00);
    tick();
    tick();
    check_val("rst_pready", 32'(pready[0]), 32'd0);
    check_val("rst_pselw", 32'(pselw[0]), 32'd0);
    check_val("rst_wr_data", 32'(wr_data[0]), 32'd0);
    check_val("rst_rd_en", 32'(rd_en[0]), 32'd0);
    preset = 1'b0;

    // Write 0xA5 to register 2 with one wait state. The bus changes during ACCESS and must be ignored.
    drv(3'b001, 1'b0, 1'b1, 4'd2, 8'hA5);
    check_val("w2_setup_pready", 32'(pready[0]), 32'd0);
    tick();
    drv(3'b001, 1'b1, 1'b0, 4'd4, 8'h3C);
    check_val("w2_acc1_pready", 32'(pready[0]), 32'd0);
    check_val("w2_acc1_pselw", 32'(pselw[0]), 32'd0);
    check_val("w2_acc1_wr_data", 32'(wr_data[0]), 32'hA5);
    tick();
    check_val("w2_acc2_pready", 32'(pready[0]), 32'd1);
    check_val("w2_acc2_pselw", 32'(pselw[0]), 32'b00100);
    check_val("w2_acc2_pslverr", 32'(pslverr[0]), 32'd0);
    check_val("w2_acc2_wr_data", 32'(wr_data[0]), 32'hA5);
    tick();
    drv(3'b000, 1'b0, 1'b0, 4'd0, 8'h00);
    check_val("w2_idle_pready", 32'(pready[0]), 32'd0);
    check_val("w2_idle_pselw", 32'(pselw[0]), 32'd0);

    // Read register at address 6, which maps to index 1.
    drv(3'b001, 1'b0, 1'b0, 4'd6, 8'h00);
    tick();
    drv(3'b001, 1'b1, 1'b0, 4'd6, 8'h00);
    check_val("r6_acc1_rd_sel", 32'(rd_sel[0]), 32'd1);
    check_val("r6_acc1_rd_en", 32'(rd_en[0]), 32'd1);
    check_val("r6_acc1_pready", 32'(pready[0]), 32'd0);
    tick();
    check_val("r6_acc2_rd_en", 32'(rd_en[0]), 32'd1);
    check_val("r6_acc2_pready", 32'(pready[0]), 32'd1);
    check_val("r6_acc2_pselw", 32'(pselw[0]), 32'd0);
    check_val("r6_acc2_pslverr", 32'(pslverr[0]), 32'd0);
    tick();
    drv(3'b000, 1'b0, 1'b0, 4'd0, 8'h00);
    check_val("r6_idle_rd_en", 32'(rd_en[0]), 32'd0);
    check_val("r6_idle_rd_sel", 32'(rd_sel[0]), 32'd1);

    // Invalid accesses: a write into the read window, then a read of a write register.
    for (int k = 0; k < 2; k++) begin
      logic       wr;
      logic [3:0] a;
      wr = (k == 0);
      a  = (k == 0) ? 4'd6 : 4'd3;
      drv(3'b001, 1'b0, wr, a, 8'h5A);
      tick();
      drv(3'b001, 1'b1, wr, a, 8'h5A);
      check_val("inv_acc1_pselw", 32'(pselw[0]), 32'd0);
      check_val("inv_acc1_rd_en", 32'(rd_en[0]), 32'd0);
      check_val("inv_acc1_pready", 32'(pready[0]), 32'd0);
      tick();
      check_val("inv_acc2_pready", 32'(pready[0]), 32'd1);
      check_val("inv_acc2_pslverr", 32'(pslverr[0]), 32'(EXP_ERR));
      check_val("inv_acc2_pselw", 32'(pselw[0]), 32'd0);
      check_val("inv_acc2_rd_en", 32'(rd_en[0]), 32'd0);
      tick();
      drv(3'b000, 1'b0, 1'b0, 4'd0, 8'h00);
      check_val("inv_idle_pslverr", 32'(pslverr[0]), 32'd0);
    end

    // Zero wait states, back-to-back writes to registers 0 and 4.
    drv(3'b010, 1'b0, 1'b1, 4'd0, 8'h11);
    check_val("b2b_setup0_pselw", 32'(pselw[1]), 32'd0);
    tick();
    drv(3'b010, 1'b1, 1'b1, 4'd0, 8'h11);
    check_val("b2b_acc0_pready", 32'(pready[1]), 32'd1);
    check_val("b2b_acc0_pselw", 32'(pselw[1]), 32'b00001);
    check_val("b2b_acc0_wr_data", 32'(wr_data[1]), 32'h11);
    tick();
    drv(3'b010, 1'b0, 1'b1, 4'd4, 8'h22);
    check_val("b2b_setup4_pready", 32'(pready[1]), 32'd0);
    check_val("b2b_setup4_pselw", 32'(pselw[1]), 32'd0);
    tick();
    drv(3'b010, 1'b1, 1'b1, 4'd4, 8'h22);
    check_val("b2b_acc4_pready", 32'(pready[1]), 32'd1);
    check_val("b2b_acc4_pselw", 32'(pselw[1]), 32'b10000);
    check_val("b2b_acc4_wr_data", 32'(wr_data[1]), 32'h22);
    tick();
    drv(3'b000, 1'b0, 1'b0, 4'd0, 8'h00);
    check_val("b2b_idle_pselw", 32'(pselw[1]), 32'd0);

    // Reset during the first access cycle of a write to register 1.
    drv(3'b001, 1'b0, 1'b1, 4'd1, 8'h77);
    tick();
    drv(3'b001, 1'b1, 1'b1, 4'd1, 8'h77);
    check_val("rstx_acc1_pselw", 32'(pselw[0]), 32'd0);
    preset = 1'b1;
    tick();
    preset = 1'b0;
    #1;
    check_val("rstx_pready", 32'(pready[0]), 32'd0);
    check_val("rstx_pselw", 32'(pselw[0]), 32'd0);
    check_val("rstx_wr_data", 32'(wr_data[0]), 32'd0);
    check_val("rstx_rd_sel", 32'(rd_sel[0]), 32'd0);
    check_val("rstx_rd_en", 32'(rd_en[0]), 32'd0);
    for (int k = 0; k < 2; k++) begin
      tick();
      check_val("rstx_hold_pready", 32'(pready[0]), 32'd0);
      check_val("rstx_hold_pselw", 32'(pselw[0]), 32'd0);
    end
    drv(3'b000, 1'b0, 1'b0, 4'd0, 8'h00);
    tick();

    // Three wait states: PSEL is dropped mid-access, then a normal write follows.
    drv(3'b100, 1'b0, 1'b1, 4'd3, 8'h99);
    tick();
    drv(3'b100, 1'b1, 1'b1, 4'd3, 8'h99);
    check_val("abort_acc1_pready", 32'(pready[2]), 32'd0);
    tick();
    drv(3'b000, 1'b0, 1'b1, 4'd3, 8'h99);
    check_val("abort_drop_pselw", 32'(pselw[2]), 32'd0);
    check_val("abort_drop_pready", 32'(pready[2]), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_val("abort_after_pready", 32'(pready[2]), 32'd0);
      check_val("abort_after_pselw", 32'(pselw[2]), 32'd0);
    end
    drv(3'b100, 1'b0, 1'b1, 4'd0, 8'h4D);
    tick();
    drv(3'b100, 1'b1, 1'b1, 4'd0, 8'h4D);
    for (int k = 0; k < 3; k++) begin
      check_val("w3_wait_pready", 32'(pready[2]), 32'd0);
      check_val("w3_wait_pselw", 32'(pselw[2]), 32'd0);
      tick();
    end
    check_val("w3_done_pready", 32'(pready[2]), 32'd1);
    check_val("w3_done_pselw", 32'(pselw[2]), 32'b00001);
    check_val("w3_done_wr_data", 32'(wr_data[2]), 32'h4D);
    tick();
    drv(3'b000, 1'b0, 1'b0, 4'd0, 8'h00);
    check_val("w3_idle_pready", 32'(pready[2]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
